// File: rtl/halftone_dot_gen.sv
// Sequential halftone dot-mask generator: scans one pixel per clock, commits atomically.
// Optional HT_DOT_CACHE_EN skips the scan when the requested level matches the last mask.
module halftone_dot_gen #(
  parameter int CELL    = 5,
  parameter int LEVEL_W = 3,
  parameter int R2_STEP = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [LEVEL_W-1:0]     level,
  output logic                   busy,
  output logic                   done,
  output logic [CELL*CELL-1:0]   dot_mask
);

  localparam int N     = CELL * CELL;
  localparam int H     = (CELL - 1) / 2;
  localparam int R2MAX = 2 * H * H;
  localparam int TMAX  = ((1 << LEVEL_W) - 1) * R2_STEP;
  localparam int VMAX  = (R2MAX > TMAX) ? R2MAX : TMAX;
  localparam int DW    = $clog2(VMAX + 1);
  localparam int IW    = $clog2(N);
  localparam int CW    = $clog2(CELL);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    COMMIT
  } state_t;

  state_t             state;
  state_t             state_n;
  logic [IW-1:0]      idx;
  logic [CW-1:0]      x;
  logic [CW-1:0]      y;
  logic [LEVEL_W-1:0] lvl;
  logic [N-1:0]       shadow;
  logic [CW-1:0]      ax;
  logic [CW-1:0]      ay;
  logic [DW-1:0]      d2;
  logic [DW-1:0]      thr;
  logic               pix;
  logic               hit;

  // Distance from centre as magnitudes, so squaring stays unsigned.
  assign ax  = (x >= CW'(H)) ? x - CW'(H) : CW'(H) - x;
  assign ay  = (y >= CW'(H)) ? y - CW'(H) : CW'(H) - y;
  assign d2  = DW'(ax) * DW'(ax) + DW'(ay) * DW'(ay);
  assign thr = DW'(lvl) * DW'(R2_STEP);
  assign pix = d2 < thr;

  assign busy = state != IDLE;

`ifdef HT_DOT_CACHE_EN
  logic [LEVEL_W-1:0] cached_level;
  logic               cache_valid;

  assign hit = cache_valid && (level == cached_level);

  always_ff @(posedge clk) begin
    if (reset) begin
      cached_level <= '0;
      cache_valid  <= 1'b0;
    end else if (state == COMMIT) begin
      cached_level <= lvl;
      cache_valid  <= 1'b1;
    end
  end
`else
  assign hit = 1'b0;
`endif

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (start) state_n = hit ? COMMIT : SCAN;
      SCAN:    if (idx == IW'(N - 1)) state_n = COMMIT;
      COMMIT:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      idx      <= '0;
      x        <= '0;
      y        <= '0;
      lvl      <= '0;
      shadow   <= '0;
      dot_mask <= '0;
      done     <= 1'b0;
    end else begin
      state <= state_n;
      done  <= (state == COMMIT);
      if (state == IDLE && start) begin
        lvl <= level;
        idx <= '0;
        x   <= '0;
        y   <= '0;
      end
      if (state == SCAN) begin
        shadow[idx] <= pix;
        idx         <= idx + 1'b1;
        if (x == CW'(CELL - 1)) begin
          x <= '0;
          y <= y + 1'b1;
        end else begin
          x <= x + 1'b1;
        end
      end
      if (state == COMMIT)
        dot_mask <= shadow;
    end
  end

endmodule

// File: tb/tb_halftone_dot_gen.sv
// Self-checking bench for halftone_dot_gen (CELL=5, LEVEL_W=3, R2_STEP=2).
// Table vectors, random levels against a geometric model, and hand-written corner sequences.
module tb_halftone_dot_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  level;
  logic        busy;
  logic        done;
  logic [24:0] dot_mask;

  int vectors = 0;
  int miscompares = 0;

  bit         m_valid = 1'b0;
  logic [2:0] m_level = '0;

  typedef struct {
    logic [2:0]  lv;
    logic [24:0] m;
    int          cnt;
  } vec_t;

  vec_t tbl[8];

  halftone_dot_gen dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .level    (level),
    .busy     (busy),
    .done     (done),
    .dot_mask (dot_mask)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  function automatic logic [24:0] ref_mask(input int lv);
    logic [24:0] m;
    m = '0;
    for (int yy = 0; yy < 5; yy++)
      for (int xx = 0; xx < 5; xx++)
        if ((xx - 2) * (xx - 2) + (yy - 2) * (yy - 2) < lv * 2)
          m[yy * 5 + xx] = 1'b1;
    return m;
  endfunction

  // Issues one request and waits for done; optionally injects an ignored start while busy.
  task automatic run_one(input logic [2:0] lv, input bit b2b, input int inj,
                         input string nm);
    logic [24:0] prev;
    int          lat;
    int          explat;
    bit          held;
    bit          hit;
    prev = dot_mask;
    held = 1'b1;
    lat = -1;
    hit = m_valid && (lv == m_level);
    explat = 26;
`ifdef HT_DOT_CACHE_EN
    if (hit) explat = 1;
`endif
    if (!b2b) @(negedge clk);
    start = 1'b1;
    level = lv;
    @(negedge clk);
    start = 1'b0;
    level = 3'($urandom);
    chk({nm, "_busy"}, 32'(busy), 32'd1);
    for (int k = 1; k <= 60 && lat < 0; k++) begin
      if (inj > 0 && k == inj) begin
        start = 1'b1;
        level = 3'd7;
      end
      if (inj > 0 && k == inj + 1) start = 1'b0;
      @(negedge clk);
      if (done) lat = k;
      else if (dot_mask !== prev) held = 1'b0;
    end
    start = 1'b0;
    chk({nm, "_latency"}, 32'(lat), 32'(explat));
    chk({nm, "_held"}, 32'(held), 32'd1);
    chk({nm, "_mask"}, 32'(dot_mask), 32'(ref_mask(int'(lv))));
    chk({nm, "_busy_done"}, 32'(busy), 32'd0);
    m_valid = 1'b1;
    m_level = lv;
  endtask

  initial begin
    bit          seen;
    logic [2:0]  rl;
    logic [24:0] first_mask;
    int          lat;

    tbl[0] = '{3'd0, 25'h0000000, 0};
    tbl[1] = '{3'd1, 25'h0023880, 5};
    tbl[2] = '{3'd2, 25'h00739C0, 9};
    tbl[3] = '{3'd3, 25'h0EFFFEE, 21};
    tbl[4] = '{3'd4, 25'h0EFFFEE, 21};
    tbl[5] = '{3'd5, 25'h1FFFFFF, 25};
    tbl[6] = '{3'd6, 25'h1FFFFFF, 25};
    tbl[7] = '{3'd7, 25'h1FFFFFF, 25};

    reset = 1'b1;
    start = 1'b0;
    level = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_mask", 32'(dot_mask), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    chk("idle_no_done", 32'(seen), 32'd0);

    foreach (tbl[i]) begin
      run_one(tbl[i].lv, 1'b0, 0, $sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d_const", i), 32'(dot_mask), 32'(tbl[i].m));
      chk($sformatf("tbl%0d_pop", i), 32'($countones(dot_mask)), 32'(tbl[i].cnt));
      @(negedge clk);
      chk($sformatf("tbl%0d_pulse", i), 32'(done), 32'd0);
    end

    rl = 3'd7;
    for (int i = 0; i < 10; i++) begin
      if ($urandom_range(0, 2) != 0) rl = 3'($urandom);
      run_one(rl, 1'b0, 0, $sformatf("rnd%0d", i));
    end

    run_one(3'd0, 1'b0, 0, "pre_ign");
    run_one(3'd2, 1'b0, 5, "ign");
    chk("ign_const", 32'(dot_mask), 32'h00739C0);

    @(negedge clk);
    start = 1'b1;
    level = 3'd5;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k < 10; k++) @(negedge clk);
    reset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    m_valid = 1'b0;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_mask", 32'(dot_mask), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("mid_rst_no_done", 32'(seen), 32'd0);

    run_one(3'd2, 1'b0, 0, "b2b_a");
    first_mask = dot_mask;
    run_one(3'd2, 1'b1, 0, "b2b_b");
    chk("b2b_same", 32'(dot_mask), 32'(first_mask));

    @(negedge clk);
    start = 1'b1;
    level = 3'd1;
    @(negedge clk);
    start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 60 && lat < 0; k++) begin
      @(negedge clk);
      if (done) lat = k;
    end
    chk("miss_latency", 32'(lat), 32'd26);
    chk("miss_mask", 32'(dot_mask), 32'h0023880);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
